// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared constants and rotating-priority pick for the register file port arbiter
//
// Purpose : default widths, the maximum supported requester count and the
//           one-hot round-robin pick used by both arbiters.
// Contents: RF_ADDR_W, RF_DATA_W, NREQ_MAX, rr_pick(req, ptr, n) -> gnt
package regfile_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 64;
  localparam int NREQ_MAX  = 4;

  // Grant the first asserted request at or after ptr, searching upward modulo n.
  // Requests at or above n are never considered.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                                  input logic [1:0]          ptr,
                                                  input int                  n);
    logic [NREQ_MAX-1:0] gnt;
    int                  idx;
    gnt = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && (gnt == '0) && req[idx[1:0]]) begin
        gnt[idx[1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot combinational grant
//
// Purpose : grants one of NREQ requests per cycle; the pointer moves to the
//           requester after the winner, and stays put when nothing is granted.
// Ports   : i_clk, i_rst_n (async active-low), i_req[NREQ], o_gnt[NREQ] (one-hot or zero)
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt
);

  logic [1:0]          r_ptr;
  logic [1:0]          w_next_ptr;
  logic [NREQ_MAX-1:0] w_req_pad;
  logic [NREQ_MAX-1:0] w_gnt_pad;

  always_comb begin
    w_req_pad = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req_pad[i] = i_req[i];
    end
  end

  assign w_gnt_pad = rr_pick(w_req_pad, r_ptr, NREQ);
  assign o_gnt     = w_gnt_pad[NREQ-1:0];

  always_comb begin
    w_next_ptr = r_ptr;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (w_gnt_pad[i]) begin
        w_next_ptr = (i == NREQ - 1) ? 2'd0 : 2'(i + 1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 2'd0;
    end else begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares register file read ports a/b and write port c among NREQ requesters
//
// Purpose : independent round-robin arbitration of the read and write paths;
//           drives register file addresses/write data/write enable and returns
//           registered read data one cycle after the read grant.
// Ports   : i_clk, i_rst_n (async active-low)
//           read  : i_rd_req, i_rd_addr_a, i_rd_addr_b -> o_rd_gnt, o_rd_valid, o_rd_data_a, o_rd_data_b
//           write : i_wr_req, i_wr_addr, i_wr_data     -> o_wr_gnt
//           rf    : o_rf_Ad_a, o_rf_Ad_b, o_rf_Ad_c, o_rf_data_wr, o_rf_wr_acc <- i_rf_data_a, i_rf_data_b
// Option  : REGFILE_ARB_BYPASS_EN forwards same-cycle write data to a matching read port.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_rd_req,
  input  logic [NREQ*ADDR_W-1:0] i_rd_addr_a,
  input  logic [NREQ*ADDR_W-1:0] i_rd_addr_b,
  output logic [NREQ-1:0]        o_rd_gnt,
  output logic [NREQ-1:0]        o_rd_valid,
  output logic [DATA_W-1:0]      o_rd_data_a,
  output logic [DATA_W-1:0]      o_rd_data_b,
  input  logic [NREQ-1:0]        i_wr_req,
  input  logic [NREQ*ADDR_W-1:0] i_wr_addr,
  input  logic [NREQ*DATA_W-1:0] i_wr_data,
  output logic [NREQ-1:0]        o_wr_gnt,
  output logic [ADDR_W-1:0]      o_rf_Ad_a,
  output logic [ADDR_W-1:0]      o_rf_Ad_b,
  output logic [ADDR_W-1:0]      o_rf_Ad_c,
  output logic [DATA_W-1:0]      o_rf_data_wr,
  output logic                   o_rf_wr_acc,
  input  logic [DATA_W-1:0]      i_rf_data_a,
  input  logic [DATA_W-1:0]      i_rf_data_b
);

  generate
    if ((NREQ < 2) || (NREQ > NREQ_MAX)) begin : g_bad_nreq
      $error("regfile_port_arbiter: NREQ=%0d unsupported, legal range is 2..4", NREQ);
    end
  endgenerate

  logic [NREQ-1:0]   w_rd_gnt;
  logic [NREQ-1:0]   w_wr_gnt;
  logic [ADDR_W-1:0] w_ad_a;
  logic [ADDR_W-1:0] w_ad_b;
  logic [ADDR_W-1:0] w_ad_c;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_cap_a;
  logic [DATA_W-1:0] w_cap_b;
  logic [NREQ-1:0]   r_rd_valid;
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_rd_req),
    .o_gnt   (w_rd_gnt)
  );

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_wr_req),
    .o_gnt   (w_wr_gnt)
  );

  // AND-OR style mux: with no grant every register file input stays at zero.
  always_comb begin
    w_ad_a    = '0;
    w_ad_b    = '0;
    w_ad_c    = '0;
    w_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_rd_gnt[i]) begin
        w_ad_a = i_rd_addr_a[i*ADDR_W +: ADDR_W];
        w_ad_b = i_rd_addr_b[i*ADDR_W +: ADDR_W];
      end
      if (w_wr_gnt[i]) begin
        w_ad_c    = i_wr_addr[i*ADDR_W +: ADDR_W];
        w_wr_data = i_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // The register file commits at the same edge the read is captured, so a
  // matching write is forwarded to give read-after-write semantics.
  assign w_cap_a = ((|w_rd_gnt) && (|w_wr_gnt) && (w_ad_a == w_ad_c)) ? w_wr_data : i_rf_data_a;
  assign w_cap_b = ((|w_rd_gnt) && (|w_wr_gnt) && (w_ad_b == w_ad_c)) ? w_wr_data : i_rf_data_b;
`else
  assign w_cap_a = i_rf_data_a;
  assign w_cap_b = i_rf_data_b;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid  <= '0;
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
    end else begin
      r_rd_valid <= w_rd_gnt;
      if (|w_rd_gnt) begin
        r_rd_data_a <= w_cap_a;
        r_rd_data_b <= w_cap_b;
      end
    end
  end

  assign o_rd_gnt     = w_rd_gnt;
  assign o_wr_gnt     = w_wr_gnt;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_data_a  = r_rd_data_a;
  assign o_rd_data_b  = r_rd_data_b;
  assign o_rf_Ad_a    = w_ad_a;
  assign o_rf_Ad_b    = w_ad_b;
  assign o_rf_Ad_c    = w_ad_c;
  assign o_rf_data_wr = w_wr_data;
  // Gated by reset so a write cannot commit while the block is held in reset.
  assign o_rf_wr_acc  = i_rst_n & (|w_wr_gnt);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        rd_req;
  logic [NREQ*ADDR_W-1:0] rd_addr_a;
  logic [NREQ*ADDR_W-1:0] rd_addr_b;
  logic [NREQ-1:0]        rd_gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [DATA_W-1:0]      rd_data_a;
  logic [DATA_W-1:0]      rd_data_b;
  logic [NREQ-1:0]        wr_req;
  logic [NREQ*ADDR_W-1:0] wr_addr;
  logic [NREQ*DATA_W-1:0] wr_data;
  logic [NREQ-1:0]        wr_gnt;
  logic [ADDR_W-1:0]      rf_Ad_a;
  logic [ADDR_W-1:0]      rf_Ad_b;
  logic [ADDR_W-1:0]      rf_Ad_c;
  logic [DATA_W-1:0]      rf_data_wr;
  logic                   rf_wr_acc;
  logic [DATA_W-1:0]      rf_data_a;
  logic [DATA_W-1:0]      rf_data_b;

  logic [DATA_W-1:0]      mem [32];

  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_req     (rd_req),
    .i_rd_addr_a  (rd_addr_a),
    .i_rd_addr_b  (rd_addr_b),
    .o_rd_gnt     (rd_gnt),
    .o_rd_valid   (rd_valid),
    .o_rd_data_a  (rd_data_a),
    .o_rd_data_b  (rd_data_b),
    .i_wr_req     (wr_req),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_gnt     (wr_gnt),
    .o_rf_Ad_a    (rf_Ad_a),
    .o_rf_Ad_b    (rf_Ad_b),
    .o_rf_Ad_c    (rf_Ad_c),
    .o_rf_data_wr (rf_data_wr),
    .o_rf_wr_acc  (rf_wr_acc),
    .i_rf_data_a  (rf_data_a),
    .i_rf_data_b  (rf_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write at the rising edge.
  assign rf_data_a = mem[rf_Ad_a];
  assign rf_data_b = mem[rf_Ad_b];
  always @(posedge clk) begin
    if (rf_wr_acc) mem[rf_Ad_c] <= rf_data_wr;
  end

  task automatic idle_inputs();
    rd_req = '0; wr_req = '0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_state();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL rst_rd_valid got %b exp 00", rd_valid); end
    checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL rst_rd_data_a got %h exp 0", rd_data_a); end
    checks++; if (rd_data_b !== 64'h0) begin errors++; $display("FAIL rst_rd_data_b got %h exp 0", rd_data_b); end
    checks++; if ({rf_Ad_a, rf_Ad_b, rf_Ad_c} !== 15'h0) begin errors++; $display("FAIL rst_rf_addr got %h exp 0", {rf_Ad_a, rf_Ad_b, rf_Ad_c}); end
    checks++; if (rf_data_wr !== 64'h0) begin errors++; $display("FAIL rst_rf_data_wr got %h exp 0", rf_data_wr); end
    checks++; if (rf_wr_acc !== 1'b0) begin errors++; $display("FAIL rst_rf_wr_acc got %b exp 0", rf_wr_acc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    apply_reset();
    wr_req = 2'b01; wr_addr[4:0] = 5'd1; wr_data[63:0] = 64'h1;
    #1;
    checks++; if (wr_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b exp 01", wr_gnt); end
    checks++; if (rf_wr_acc !== 1'b1) begin errors++; $display("FAIL wr_acc got %b exp 1", rf_wr_acc); end
    checks++; if (rf_Ad_c !== 5'd1) begin errors++; $display("FAIL wr_Ad_c got %0d exp 1", rf_Ad_c); end
    checks++; if (rf_data_wr !== 64'h1) begin errors++; $display("FAIL wr_data got %h exp 1", rf_data_wr); end
    @(posedge clk); #1;
    wr_req = 2'b00;
    rd_req = 2'b01; rd_addr_a[4:0] = 5'd1; rd_addr_b[4:0] = 5'd0;
    #1;
    checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL wrrd_rd_gnt got %b exp 01", rd_gnt); end
    checks++; if (rf_Ad_a !== 5'd1) begin errors++; $display("FAIL wrrd_Ad_a got %0d exp 1", rf_Ad_a); end
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL wrrd_valid_early got %b exp 00", rd_valid); end
    @(posedge clk); #1;
    rd_req = 2'b00;
    checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL wrrd_valid got %b exp 01", rd_valid); end
    checks++; if (rd_data_a !== 64'h1) begin errors++; $display("FAIL wrrd_data_a got %h exp 1", rd_data_a); end
    checks++; if (rd_data_b !== 64'h0) begin errors++; $display("FAIL wrrd_data_b got %h exp 0", rd_data_b); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL wrrd_valid_pulse got %b exp 00", rd_valid); end
    checks++; if (rd_data_a !== 64'h1) begin errors++; $display("FAIL wrrd_data_hold got %h exp 1", rd_data_a); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [6];
    logic [1:0] prev;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    rd_req = 2'b11; rd_addr_a = {5'd2, 5'd1}; rd_addr_b = {5'd0, 5'd0};
    prev = 2'b00;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (rd_gnt !== exp_gnt[c]) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", c, rd_gnt, exp_gnt[c]); end
      checks++; if (rd_valid !== prev) begin errors++; $display("FAIL rr_valid[%0d] got %b exp %b", c, rd_valid, prev); end
      prev = exp_gnt[c];
      @(posedge clk); #1;
    end
    rd_req = 2'b00;
    checks++; if (rd_valid !== 2'b10) begin errors++; $display("FAIL rr_valid_last got %b exp 10", rd_valid); end
  endtask

  task automatic test_concurrent();
    apply_reset();
    rd_req = 2'b01; rd_addr_a[4:0] = 5'd2;
    wr_req = 2'b10; wr_addr[9:5] = 5'd3; wr_data[127:64] = 64'hAA;
    #1;
    checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL cc_rd_gnt got %b exp 01", rd_gnt); end
    checks++; if (wr_gnt !== 2'b10) begin errors++; $display("FAIL cc_wr_gnt got %b exp 10", wr_gnt); end
    checks++; if (rf_Ad_c !== 5'd3) begin errors++; $display("FAIL cc_Ad_c got %0d exp 3", rf_Ad_c); end
    checks++; if (rf_data_wr !== 64'hAA) begin errors++; $display("FAIL cc_data_wr got %h exp aa", rf_data_wr); end
    checks++; if (rf_Ad_a !== 5'd2) begin errors++; $display("FAIL cc_Ad_a got %0d exp 2", rf_Ad_a); end
    @(posedge clk); #1;
    wr_req = 2'b00;
    rd_req = 2'b10; rd_addr_a[9:5] = 5'd3;
    checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL cc_old_a got %h exp 0", rd_data_a); end
    #1;
    checks++; if (rd_gnt !== 2'b10) begin errors++; $display("FAIL cc_rd_gnt2 got %b exp 10", rd_gnt); end
    @(posedge clk); #1;
    rd_req = 2'b00;
    checks++; if (rd_valid !== 2'b10) begin errors++; $display("FAIL cc_valid got %b exp 10", rd_valid); end
    checks++; if (rd_data_a !== 64'hAA) begin errors++; $display("FAIL cc_read3 got %h exp aa", rd_data_a); end
  endtask

  task automatic test_hazard();
    logic [63:0] exp_haz;
`ifdef REGFILE_ARB_BYPASS_EN
    exp_haz = 64'h9;
`else
    exp_haz = 64'h7;
`endif
    apply_reset();
    wr_req = 2'b01; wr_addr[4:0] = 5'd5; wr_data[63:0] = 64'h7;
    @(posedge clk); #1;
    // write pointer now at 1, so requester 1 wins the write
    wr_req = 2'b10; wr_addr[9:5] = 5'd5; wr_data[127:64] = 64'h9;
    rd_req = 2'b01; rd_addr_a[4:0] = 5'd5; rd_addr_b[4:0] = 5'd5;
    #1;
    checks++; if ({rd_gnt, wr_gnt} !== 4'b0110) begin errors++; $display("FAIL hz_gnts got %b exp 0110", {rd_gnt, wr_gnt}); end
    @(posedge clk); #1;
    wr_req = 2'b00; rd_req = 2'b00;
    checks++; if (rd_data_a !== exp_haz) begin errors++; $display("FAIL hz_data_a got %h exp %h", rd_data_a, exp_haz); end
    checks++; if (rd_data_b !== exp_haz) begin errors++; $display("FAIL hz_data_b got %h exp %h", rd_data_b, exp_haz); end
    rd_req = 2'b01; rd_addr_a[4:0] = 5'd5;
    @(posedge clk); #1;
    rd_req = 2'b00;
    checks++; if (rd_data_a !== 64'h9) begin errors++; $display("FAIL hz_after got %h exp 9", rd_data_a); end
  endtask

  task automatic test_withdraw();
    apply_reset();
    rd_req = 2'b11; rd_addr_a = {5'd3, 5'd1};
    #1;
    checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL wd_gnt0 got %b exp 01", rd_gnt); end
    @(posedge clk); #1;
    rd_req = 2'b01;
    #1;
    checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL wd_gnt1 got %b exp 01", rd_gnt); end
    checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL wd_valid0 got %b exp 01", rd_valid); end
    @(posedge clk); #1;
    rd_req = 2'b00;
    checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL wd_valid1 got %b exp 01", rd_valid); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL wd_valid2 got %b exp 00", rd_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rd_req = 2'b11; rd_addr_a = {5'd3, 5'd3};
    wr_req = 2'b11; wr_addr = {5'd9, 5'd8}; wr_data = {64'h22, 64'h11};
    @(posedge clk); #1;
    checks++; if (rd_data_a !== 64'hAA) begin errors++; $display("FAIL rm_pre_data got %h exp aa", rd_data_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL rm_valid got %b exp 00", rd_valid); end
    checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL rm_data_a got %h exp 0", rd_data_a); end
    checks++; if (rf_wr_acc !== 1'b0) begin errors++; $display("FAIL rm_wr_acc got %b exp 0", rf_wr_acc); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL rm_rd_gnt got %b exp 01", rd_gnt); end
    checks++; if (wr_gnt !== 2'b01) begin errors++; $display("FAIL rm_wr_gnt got %b exp 01", wr_gnt); end
    checks++; if (rf_wr_acc !== 1'b1) begin errors++; $display("FAIL rm_wr_acc_on got %b exp 1", rf_wr_acc); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset_state();
    test_write_read();
    test_round_robin();
    test_concurrent();
    test_hazard();
    test_withdraw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the 32x64 register file's two read ports (addresses a/b) and single write port (address c) among NREQ requesters, e.g. ALU and load unit.
- Uses independent round-robin arbitration for the read and write paths.
- Sits between the requesters and the register file; drives the register file's address, write-data and write-enable inputs, and returns registered read data.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 5, register address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  NREQ  per-requester read request; held until granted.
- rd_addr_a  in  NREQ*ADDR_W  read address a; requester i occupies slice i.
- rd_addr_b  in  NREQ*ADDR_W  read address b.
- rd_gnt  out  NREQ  one-hot read grant; combinational, same cycle.
- rd_valid  out  NREQ  one-hot response strobe, one cycle after grant.
- rd_data_a  out  DATA_W  registered read data a, broadcast to all requesters.
- rd_data_b  out  DATA_W  registered read data b, broadcast to all requesters.
- wr_req  in  NREQ  per-requester write request; held until granted.
- wr_addr  in  NREQ*ADDR_W  write address.
- wr_data  in  NREQ*DATA_W  write data.
- wr_gnt  out  NREQ  one-hot write grant; combinational.
- rf_Ad_a  out  ADDR_W  to register file read port a.
- rf_Ad_b  out  ADDR_W  to register file read port b.
- rf_Ad_c  out  ADDR_W  to register file write address.
- rf_data_wr  out  DATA_W  to register file write data.
- rf_wr_acc  out  1  to register file write enable.
- rf_data_a  in  DATA_W  from register file, combinational read a.
- rf_data_b  in  DATA_W  from register file, combinational read b.

Behaviour:
- Reset (async, rst_n=0):
  - rd_ptr=0, wr_ptr=0.
  - rd_valid=0, rd_data_a=0, rd_data_b=0.
  - With no requests, rf_Ad_*=0, rf_data_wr=0, rf_wr_acc=0.
- Round-robin grant:
  - Grant the first asserted request at or after the pointer, searching upward modulo NREQ.
  - On a grant to i, the pointer becomes (i+1) mod NREQ at the next edge.
  - The pointer is unchanged when there is no grant.
- Grant shape:
  - rd_gnt and wr_gnt are each one-hot or zero.
  - Read and write arbitration are independent; both may grant in the same cycle, to the same or different requesters.
- Read path:
  - rf_Ad_a/rf_Ad_b are muxed combinationally from the granted requester's addresses.
  - At the rising edge, rf_data_a/b are captured into rd_data_a/b and rd_valid = registered rd_gnt.
  - Latency is 1 cycle. rd_valid is a single-cycle pulse.
  - rd_data_* holds its value when rd_valid=0.
- Write path:
  - rf_Ad_c and rf_data_wr are muxed from the granted requester; rf_wr_acc = |wr_gnt.
  - The register file commits at the same edge.
  - A requester may drop wr_req the cycle after wr_gnt.
- Handshake:
  - A request counts as accepted only in a cycle where its grant is high.
  - A requester that deasserts before its grant is simply skipped; no error is flagged.
- Back-to-back: a requester holding its request continuously is granted every NREQ cycles at worst when all requesters are active, and every cycle when it is alone.
- Same-cycle read/write to the same address: the read returns the old contents (read-before-write), unless the optional feature below is enabled.
- Reset mid-operation:
  - Any pending rd_valid is cleared and pointers return to 0.
  - A write granted in the reset cycle is not guaranteed, because rf_wr_acc is forced to 0 while rst_n=0.
- Unsupported NREQ: for NREQ outside 2..4, elaboration stops with an error message.

Optional Feature:
- Macro: REGFILE_ARB_BYPASS_EN.
- With the macro defined: when the read and write grants are both active in a cycle and rf_Ad_a == rf_Ad_c, the captured rd_data_a takes rf_data_wr instead of rf_data_a. The same rule applies independently to port b.
- Without the macro: no forwarding; old data is returned as described above.

Decomposition:
- Package regfile_arb_pkg:
  - ADDR_W=5 and DATA_W=64 defaults.
  - NREQ_MAX=4.
  - Function for the rotating-priority one-hot pick: inputs req and ptr, output gnt.
- Sub-module rr_arbiter: NREQ req in, one-hot gnt out, internal pointer register with clk/rst_n. It is instantiated twice, once for reads and once for writes.

Test Plan:
- Reset: assert rst_n=0 mid-traffic -> rd_valid=0, rd_data_*=0, rf_wr_acc=0 immediately; the first grant after release goes to requester 0 when all requesters request.
- Single write then read: req0 writes addr 1 data 64'h1 -> wr_gnt=01, rf_wr_acc=1, rf_Ad_c=1. Next cycle req0 reads a=1, b=0 -> rd_valid=01 one cycle later, rd_data_a=64'h1, rd_data_b=0.
- Round-robin fairness: both requesters hold rd_req for 6 cycles -> rd_gnt sequence 01,10,01,10,01,10; rd_valid follows delayed by one cycle.
- Concurrent independent paths: req0 reads addr 2 while req1 writes addr 3 data 64'hAA -> both granted in the same cycle; a later read of addr 3 returns 64'hAA.
- Same-address hazard: req0 reads addr 5 (old value 64'h7) while req1 writes 64'h9 to addr 5 -> rd_data_a=64'h7 without REGFILE_ARB_BYPASS_EN, and 64'h9 with it.
- Request withdrawn: req1 asserts rd_req for 1 cycle while req0 holds the grant -> req1 is never granted, and no rd_valid is issued for req1.
